// File: rtl/m_reduce_arb.sv
// Round-robin arbiter for two requesters sharing one serial AND/OR/XOR reduction engine.
// A granted operand is scanned LSB-first, one bit per cycle, and the result is posted on w_led.
module m_reduce_arb #(
  parameter int WIDTH = 5
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_req0,
  input  logic [WIDTH-1:0] w_din0,
  input  logic             w_req1,
  input  logic [WIDTH-1:0] w_din1,
  output logic             w_gnt0,
  output logic             w_gnt1,
  output logic             w_busy,
  output logic             w_vld,
  output logic             w_id,
  output logic [2:0]       w_led
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             and_q, and_d, or_q, or_d, xor_q, xor_d;
  logic             last_q, last_d, own_q, own_d, id_q, id_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d, vld_q, vld_d;
  logic [2:0]       led_q, led_d;
  logic             any_req, win, bit_b, last_bit;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    any_req  = w_req0 | w_req1;
    // On a tie the requester that did not win last time takes the grant.
    win      = (w_req0 & w_req1) ? ~last_q : w_req1;
    last_bit = (cnt_q == CW'(WIDTH - 1));
    state_d  = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req)  state_d = S_SCAN;
      S_SCAN:  if (last_bit) state_d = S_DONE;
      S_DONE:                state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (state_q != S_IDLE);
    w_gnt0 = gnt0_q;
    w_gnt1 = gnt1_q;
    w_vld  = vld_q;
    w_id   = id_q;
    w_led  = led_q;
  end

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    and_d  = and_q;
    or_d   = or_q;
    xor_d  = xor_q;
    last_d = last_q;
    own_d  = own_q;
    id_d   = id_q;
    led_d  = led_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    vld_d  = 1'b0;
    bit_b  = sh_q[0];
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          sh_d   = win ? w_din1 : w_din0;
          cnt_d  = '0;
          and_d  = 1'b1;
          or_d   = 1'b0;
          xor_d  = 1'b0;
          gnt0_d = ~win;
          gnt1_d = win;
          own_d  = win;
          last_d = win;
        end
      end
      S_SCAN: begin
        and_d = and_q & bit_b;
        or_d  = or_q | bit_b;
        xor_d = xor_q ^ bit_b;
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          led_d = {xor_q ^ bit_b, or_q | bit_b, and_q & bit_b};
          id_d  = own_q;
          vld_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      and_q  <= 1'b0;
      or_q   <= 1'b0;
      xor_q  <= 1'b0;
      last_q <= 1'b1;
      own_q  <= 1'b0;
      id_q   <= 1'b0;
      led_q  <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      and_q  <= and_d;
      or_q   <= or_d;
      xor_q  <= xor_d;
      last_q <= last_d;
      own_q  <= own_d;
      id_q   <= id_d;
      led_q  <= led_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: tb/tb_m_reduce_arb.sv
// Bench for m_reduce_arb: phase-based reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_m_reduce_arb;
  localparam int W = 5;

  logic         w_clk = 1'b0;
  logic         w_rst;
  logic         w_req0, w_req1;
  logic [W-1:0] w_din0, w_din1;
  logic         w_gnt0, w_gnt1, w_busy, w_vld, w_id;
  logic [2:0]   w_led;

  int tests = 0;
  int errs  = 0;
  int cyc   = 0;

  m_reduce_arb #(.WIDTH(W)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_req0(w_req0), .w_din0(w_din0),
    .w_req1(w_req1), .w_din1(w_din1),
    .w_gnt0(w_gnt0), .w_gnt1(w_gnt1), .w_busy(w_busy),
    .w_vld(w_vld), .w_id(w_id), .w_led(w_led)
  );

  always #5 w_clk = ~w_clk;
  always @(posedge w_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: ph counts cycles since capture (0 = idle), result from reduction operators.
  int         ph;
  bit         m_last, m_own, m_id;
  logic [2:0] m_led;
  logic [W-1:0] m_op;

  always @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      ph = 0; m_last = 1'b1; m_own = 1'b0; m_id = 1'b0; m_led = 3'b000;
    end else if (ph == 0) begin
      if (w_req0 || w_req1) begin
        m_own  = (w_req0 && w_req1) ? !m_last : w_req1;
        m_last = m_own;
        m_op   = m_own ? w_din1 : w_din0;
        ph     = 1;
      end
    end else if (ph == W + 1) begin
      ph = 0;
    end else begin
      ph++;
      if (ph == W + 1) begin
        m_led = {^m_op, |m_op, &m_op};
        m_id  = m_own;
      end
    end
  end

  always @(negedge w_clk) begin
    chk("cmp_gnt0", w_gnt0, (ph == 1) && !m_own);
    chk("cmp_gnt1", w_gnt1, (ph == 1) && m_own);
    chk("cmp_busy", w_busy, ph != 0);
    chk("cmp_vld",  w_vld,  ph == W + 1);
    chk("cmp_id",   w_id,   m_id);
    chk("cmp_led",  w_led,  m_led);
  end

  task automatic wait_gnt(input bit who, output int at);
    bit ok = 1'b0;
    at = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge w_clk);
      if (who ? w_gnt1 : w_gnt0) begin at = cyc; ok = 1'b1; break; end
    end
    chk("gnt_seen", ok, 1);
  endtask

  task automatic wait_vld(output int at);
    bit ok = 1'b0;
    at = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge w_clk);
      if (w_vld) begin at = cyc; ok = 1'b1; break; end
    end
    chk("vld_seen", ok, 1);
  endtask

  task automatic do_op(input bit who, input logic [W-1:0] d, input logic [2:0] exp_led);
    int g, v;
    @(negedge w_clk); #2;
    if (who) begin w_req1 = 1'b1; w_din1 = d; end
    else     begin w_req0 = 1'b1; w_din0 = d; end
    wait_gnt(who, g);
    #2;
    // Operand changes after capture must not affect the result.
    if (who) begin w_req1 = 1'b0; w_din1 = ~d; end
    else     begin w_req0 = 1'b0; w_din0 = ~d; end
    wait_vld(v);
    chk("op_led", w_led, exp_led);
    chk("op_id", w_id, who);
    chk("op_latency", v - g, W);
    chk("op_busy_done", w_busy, 1);
    @(negedge w_clk);
    chk("op_vld_drop", w_vld, 0);
    chk("op_busy_drop", w_busy, 0);
    chk("op_led_hold", w_led, exp_led);
  endtask

  initial begin
    int g, c, n, v;
    int gid[4];
    int gcy[4];
    bit saw;
    w_rst = 1'b1; w_req0 = 1'b0; w_req1 = 1'b0; w_din0 = '0; w_din1 = '0;
    repeat (3) @(negedge w_clk);
    chk("rst_led", w_led, 3'b000);
    chk("rst_busy", w_busy, 0);
    chk("rst_id", w_id, 0);
    #2 w_rst = 1'b0;

    do_op(1'b0, 5'b11111, 3'b111);
    do_op(1'b1, 5'b00010, 3'b110);

    // Asynchronous reset two cycles into an operation.
    @(negedge w_clk); #2;
    w_req0 = 1'b1; w_din0 = 5'b10110;
    wait_gnt(1'b0, g);
    #2 w_req0 = 1'b0;
    @(negedge w_clk); @(negedge w_clk);
    #2 w_rst = 1'b1;
    #1;
    chk("arst_led", w_led, 3'b000);
    chk("arst_busy", w_busy, 0);
    chk("arst_vld", w_vld, 0);
    chk("arst_id", w_id, 0);
    chk("arst_gnt", {w_gnt1, w_gnt0}, 2'b00);
    @(negedge w_clk); #2 w_rst = 1'b0;
    saw = 1'b0;
    repeat (8) begin @(negedge w_clk); if (w_vld) saw = 1'b1; end
    chk("arst_no_vld", saw, 0);

    do_op(1'b1, 5'b10101, 3'b110);
    do_op(1'b1, 5'b00000, 3'b000);

    // Tie straight after reset: grants alternate 0,1,0,1, one per W+2 cycles.
    @(negedge w_clk); #2 w_rst = 1'b1;
    @(negedge w_clk); #2 w_rst = 1'b0;
    w_req0 = 1'b1; w_req1 = 1'b1; w_din0 = 5'b00111; w_din1 = 5'b01001;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge w_clk);
      if (w_gnt0 || w_gnt1) begin gid[n] = w_gnt1; gcy[n] = cyc; n++; end
    end
    #2 begin w_req0 = 1'b0; w_req1 = 1'b0; end
    chk("tie_count", n, 4);
    chk("tie_order", {gid[0][0], gid[1][0], gid[2][0], gid[3][0]}, 4'b0101);
    chk("tie_gap01", gcy[1] - gcy[0], 7);
    chk("tie_gap12", gcy[2] - gcy[1], 7);
    chk("tie_gap23", gcy[3] - gcy[2], 7);
    wait_vld(v);
    chk("tie_last_led", w_led, 3'b010);
    chk("tie_last_id", w_id, 1);
    repeat (3) @(negedge w_clk);

    // Late request from requester 1 during requester 0's scan.
    #2 begin w_req0 = 1'b1; w_din0 = 5'b01100; end
    wait_gnt(1'b0, g);
    #2 w_req0 = 1'b0;
    @(negedge w_clk); @(negedge w_clk);
    #2 begin w_req1 = 1'b1; w_din1 = 5'b11011; end
    wait_gnt(1'b1, c);
    chk("late_gnt1_edge", c - g, 7);
    #2 w_req1 = 1'b0;
    wait_vld(v);
    chk("late_led", w_led, 3'b010);
    chk("late_id", w_id, 1);
    chk("late_latency", v - c, W);
    repeat (3) @(negedge w_clk);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/m_reduce_arb.md
# m_reduce_arb

Two-requester round-robin arbiter and sequencer for a shared serial reduction engine. Each granted request captures a WIDTH-bit operand, scans it LSB-first one bit per cycle, and produces its AND, OR and XOR reductions. The result is registered on a 3-bit LED bus with a one-cycle valid pulse tagged with the requester ID. It sits between the button/switch front-ends and the LED driver, so one reduction unit serves two sources.

## Interface
- WIDTH, 5, operand width in bits; must be at least 2.

- w_clk  in  1  system clock; all state changes on the rising edge.
- w_rst  in  1  asynchronous, active-high reset.
- w_req0  in  1  requester 0 request; held high until w_gnt0 is seen.
- w_din0  in  WIDTH  requester 0 operand; stable while w_req0 is high.
- w_req1  in  1  requester 1 request.
- w_din1  in  WIDTH  requester 1 operand.
- w_gnt0  out  1  one-cycle pulse: requester 0 operand captured.
- w_gnt1  out  1  one-cycle pulse: requester 1 operand captured.
- w_busy  out  1  high whenever FSM is not IDLE.
- w_vld  out  1  one-cycle pulse: new result on w_led.
- w_id  out  1  requester that owns the current w_led value.
- w_led  out  3  result: [0]=AND, [1]=OR, [2]=XOR of operand bits.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If any request is high at a clock edge, pick a winner.
  - Load the winner's operand into a WIDTH-bit shift register and clear the bit counter to 0.
  - Set accumulators to and=1, or=0, xor=0.
  - Register the winner's gnt=1 and record the owner ID.
  - Go to SCAN.
- Arbitration:
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_id.
  - last_id updates on every grant; reset value is 1, so requester 0 wins the first tie.
- SCAN, each edge:
  - Update and&=b, or|=b, xor^=b, where b is the shift register LSB.
  - Shift right and increment the counter.
  - On the edge that processes bit WIDTH-1:
    - Register the final reductions into w_led and the owner into w_id.
    - Set w_vld=1 and go to DONE.
- DONE:
  - Next edge clears w_vld and goes to IDLE.
  - Requests are not arbitrated in DONE.
- Requests in SCAN or DONE are ignored, not queued.
  - A request still high on return to IDLE is arbitrated as a new request.
  - A requester that keeps req high after its gnt gets a second grant.
- w_din is sampled only on the capture edge; later changes do not affect the result in flight.
- w_led and w_id hold their values until the next completion.
- Counter width is clog2(WIDTH)+1 bits; it never wraps within one operation.

## Timing
- Reset values (asynchronous, immediate on w_rst=1): state IDLE, w_gnt0/1=0, w_busy=0, w_vld=0, w_id=0, w_led=000, last_id=1.
  - The shift register, counter and accumulators are cleared.
- Reset during SCAN or DONE aborts the operation. No w_vld is produced, and w_led returns to 000.
- Cycle accounting, with E0 the capture edge:
  - w_gntN and w_busy are high in the cycle after E0; gnt drops at E1.
  - Bits are processed at E1..E_WIDTH.
  - w_vld is high from E_WIDTH to E_WIDTH+1.
  - The FSM is in IDLE after E_WIDTH+1; the earliest next capture is E_WIDTH+2.
- Latency from capture to valid is WIDTH cycles; throughput is one result per WIDTH+2 cycles.
- w_busy covers E0 to E_WIDTH+1.

## Test plan
- Reset: assert w_rst mid-cycle with no clock edge -> all outputs 0 and w_led=000 immediately.
- Single request: w_req0=1, w_din0=11111 captured at E0 -> w_gnt0 high for E0-E1. At E5: w_led=111, w_id=0, w_vld high for exactly one cycle. w_busy falls at E6.
- Requester 1 operands:
  - w_din1=00010 -> w_led=110 (AND 0, OR 1, XOR 1), w_id=1.
  - Then w_din1=00000 -> w_led=000 with w_vld pulsed.
- Tie after reset: w_req0 and w_req1 held high continuously -> grant order 0,1,0,1. Consecutive grants are exactly 7 cycles apart when WIDTH=5.
- Reset mid-operation: pulse w_rst two cycles after w_gnt0 -> no w_vld, w_led=000, w_busy=0. A subsequent w_req1 with 10101 -> w_led=110, w_id=1.
- Late request: w_req1 rises during requester 0's SCAN -> no w_gnt1 until the FSM returns to IDLE. w_gnt1 is then asserted at the first IDLE edge, E7 relative to requester 0's capture.
